line_feed_scheduler: RTL and testbench

- Sequences pixel delivery from an upstream 8-bit pixel stream into the 4-line-buffer 3x3 window generator, using line credits so no line buffer is overwritten before it has been read.
- Each downstream line-consumed interrupt returns one credit.
- At end of frame it injects zero-valued padding lines so the last window rows are produced, then reports frame completion.
- Sits between the DMA/stream input and the line-buffer controller.

---
 rtl/line_feed_scheduler.sv | 162 ++++++++++++++++
 tb/tb_line_feed_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_feed_scheduler.sv
// Credit-gated pixel feeder for the 4-line-buffer 3x3 window generator.
// Appends zero padding lines after the frame and reports completion once drained.
module line_feed_scheduler #(
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int LINE_CREDITS = 4,
  parameter int PAD_LINES    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_s_data,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  output logic [7:0]  o_pixel_data,
  output logic        o_pixel_data_valid,
  input  logic        i_intr,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [11:0] o_lines_out
);

  localparam int PW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int CW = $clog2(LINE_CREDITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [PW-1:0] PIX_LAST   = PW'(IMG_W - 1);
  localparam logic [CW-1:0] CRED_MAX   = CW'(LINE_CREDITS);
  localparam logic [11:0]   IN_LINES   = 12'(IMG_H);
  localparam logic [11:0]   PAD_TOTAL  = 12'(PAD_LINES);
  localparam logic [11:0]   DONE_LINES = 12'(IMG_H + PAD_LINES - 2);

  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] credits_q,   credits_d;
  logic [PW-1:0] pix_cnt_q,   pix_cnt_d;
  logic [11:0]   in_lines_q,  in_lines_d;
  logic [11:0]   pad_lines_q, pad_lines_d;
  logic [11:0]   lines_out_q, lines_out_d;
  logic [7:0]    pix_data_q,  pix_data_d;
  logic          pix_valid_q, pix_valid_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;

  logic xfer, pad_emit, line_done, intr_ok;

  // A line may only complete while a credit is held, so credits never underflow.
  assign o_s_ready = (state_q == S_FEED) && (credits_q != '0);
  assign xfer      = i_s_valid && o_s_ready;
  assign pad_emit  = (state_q == S_PAD) && (credits_q != '0);
  assign line_done = (xfer || pad_emit) && (pix_cnt_q == PIX_LAST);
  assign intr_ok   = i_intr && (state_q != S_IDLE);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    credits_d   = credits_q;
    pix_cnt_d   = pix_cnt_q;
    in_lines_d  = in_lines_q;
    pad_lines_d = pad_lines_q;
    lines_out_d = lines_out_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_FEED;
          credits_d   = CRED_MAX;
          pix_cnt_d   = '0;
          in_lines_d  = '0;
          pad_lines_d = '0;
          lines_out_d = '0;
          busy_d      = 1'b1;
        end
      end
      S_FEED: begin
        if (xfer) begin
          pix_data_d  = i_s_data;
          pix_valid_d = 1'b1;
          pix_cnt_d   = line_done ? '0 : pix_cnt_q + 1'b1;
          if (line_done) begin
            in_lines_d = in_lines_q + 12'd1;
            if (in_lines_q + 12'd1 == IN_LINES) begin
              state_d = (PAD_LINES == 0) ? S_DRAIN : S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        if (pad_emit) begin
          pix_data_d  = 8'd0;
          pix_valid_d = 1'b1;
          pix_cnt_d   = line_done ? '0 : pix_cnt_q + 1'b1;
          if (line_done) begin
            pad_lines_d = pad_lines_q + 12'd1;
            if (pad_lines_q + 12'd1 == PAD_TOTAL) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      default: begin
        if (lines_out_q == DONE_LINES) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
    endcase

    // A returned credit and a consumed one in the same cycle cancel out.
    if (intr_ok && !line_done) begin
      credits_d = (credits_q == CRED_MAX) ? credits_q : credits_q + 1'b1;
    end else if (line_done && !intr_ok) begin
      credits_d = credits_q - 1'b1;
    end

    if (intr_ok) begin
      lines_out_d = lines_out_q + 12'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      credits_q   <= '0;
      pix_cnt_q   <= '0;
      in_lines_q  <= '0;
      pad_lines_q <= '0;
      lines_out_q <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      pix_cnt_q   <= pix_cnt_d;
      in_lines_q  <= in_lines_d;
      pad_lines_q <= pad_lines_d;
      lines_out_q <= lines_out_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_pixel_data       = pix_data_q;
  assign o_pixel_data_valid = pix_valid_q;
  assign o_busy             = busy_q;
  assign o_frame_done       = done_q;
  assign o_lines_out        = lines_out_q;

endmodule

// File: tb/tb_line_feed_scheduler.sv
// Directed bench for line_feed_scheduler with an 8x6 image, 4 credits and 2 pad lines.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_line_feed_scheduler;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_s_data = 8'd0;
  logic        i_s_valid = 1'b0;
  logic        o_s_ready;
  logic [7:0]  o_pixel_data;
  logic        o_pixel_data_valid;
  logic        i_intr;
  logic        o_busy;
  logic        o_frame_done;
  logic [11:0] o_lines_out;

  logic man_intr = 1'b0;
  logic auto_intr = 1'b0;
  assign i_intr = man_intr | auto_intr;

  always #5 clk = ~clk;

  line_feed_scheduler #(
    .IMG_W(8), .IMG_H(6), .LINE_CREDITS(4), .PAD_LINES(2)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
    .i_intr(i_intr), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_lines_out(o_lines_out)
  );

  int n_asserts = 0;
  int n_fails = 0;

  // Bench-side bookkeeping
  int cycles = 0, in_idx = 0, out_idx = 0, data_errs = 0, mirror_errs = 0;
  int done_cnt = 0, done_lines = 0, done_busy = 0, budget = 0, base = 0;
  logic src_en = 1'b0, toggle_mode = 1'b0, mirror_en = 1'b0, last_xfer = 1'b0;
  logic auto_en = 1'b0;
  int vcnt = 0, cd = 0;

  function automatic logic [7:0] pix_val(int i);
    return 8'((i % 251) + 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs, then drive inputs for the next rising edge.
  task automatic tick();
    logic [7:0] exp_px;
    @(negedge clk);
    cycles++;
    if (mirror_en && (o_pixel_data_valid !== last_xfer)) mirror_errs++;
    if (o_pixel_data_valid === 1'b1) begin
      exp_px = (out_idx < in_idx) ? pix_val(out_idx) : 8'd0;
      if (o_pixel_data !== exp_px) data_errs++;
      out_idx++;
    end
    if (o_frame_done === 1'b1) begin
      done_cnt++;
      done_lines = int'(o_lines_out);
      done_busy = int'(o_busy);
    end
    i_s_valid = src_en && (!toggle_mode || cycles[0]);
    i_s_data = pix_val(in_idx);
    last_xfer = i_s_valid && o_s_ready;
    if (last_xfer) in_idx++;
  endtask

  task automatic clear_counts();
    in_idx = 0; out_idx = 0; data_errs = 0; mirror_errs = 0;
    done_cnt = 0; last_xfer = 1'b0;
  endtask

  task automatic do_reset();
    auto_en = 1'b0;
    src_en = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    clear_counts();
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Downstream model: one line-consumed pulse two cycles after each completed
  // output line, once three lines are buffered.
  always @(negedge clk) begin
    auto_intr = 1'b0;
    if (!auto_en) begin
      vcnt = 0;
      cd = 0;
    end else begin
      if (cd != 0) begin
        cd--;
        if (cd == 0) auto_intr = 1'b1;
      end
      if (o_pixel_data_valid === 1'b1) begin
        vcnt++;
        if ((vcnt % 8 == 0) && (vcnt >= 24)) cd = 2;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    i_rst = 1'b0;
    check("rst_ready", 32'(o_s_ready), 0);
    check("rst_valid", 32'(o_pixel_data_valid), 0);
    check("rst_data", 32'(o_pixel_data), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_frame_done), 0);
    check("rst_lines_out", 32'(o_lines_out), 0);

    // Valid held high while idle is not accepted
    src_en = 1'b1;
    repeat (3) tick();
    check("idle_no_xfer", 32'(in_idx), 0);

    // No credits returned: exactly four lines then a permanent stall
    mirror_en = 1'b1;
    start_frame();
    check("start_busy", 32'(o_busy), 1);
    repeat (60) tick();
    check("stall_xfers", 32'(in_idx), 32);
    check("stall_ready", 32'(o_s_ready), 0);
    check("stall_credits", 32'(dut.credits_q), 0);
    start_frame();
    check("busy_start_ignored", 32'(dut.credits_q), 0);

    // One returned credit unlocks exactly one more line
    man_intr = 1'b1;
    tick();
    man_intr = 1'b0;
    check("intr_ready", 32'(o_s_ready), 1);
    check("intr_lines_out", 32'(o_lines_out), 1);
    repeat (30) tick();
    check("one_line_xfers", 32'(in_idx), 40);
    check("one_line_ready", 32'(o_s_ready), 0);
    check("one_line_outs", 32'(out_idx), 40);
    check("one_line_data", 32'(data_errs), 0);
    check("one_line_mirror", 32'(mirror_errs), 0);
    mirror_en = 1'b0;

    // Credit saturation, then simultaneous last pixel and returned credit
    do_reset();
    start_frame();
    man_intr = 1'b1;
    tick();
    man_intr = 1'b0;
    check("sat_credits", 32'(dut.credits_q), 4);
    check("sat_lines_out", 32'(o_lines_out), 1);
    src_en = 1'b1;
    budget = 0;
    while (in_idx < 32 && budget < 200) begin
      tick();
      budget++;
    end
    check("pre_sim_credits", 32'(dut.credits_q), 1);
    man_intr = 1'b1;
    tick();
    man_intr = 1'b0;
    check("sim_credits", 32'(dut.credits_q), 1);
    check("sim_ready", 32'(o_s_ready), 1);
    check("sim_no_bubble", 32'(in_idx), 33);
    check("sim_lines_out", 32'(o_lines_out), 2);

    // Upstream valid toggling every other cycle
    do_reset();
    mirror_en = 1'b1;
    toggle_mode = 1'b1;
    src_en = 1'b1;
    start_frame();
    base = in_idx;
    repeat (20) tick();
    check("toggle_xfers", 32'(in_idx - base), 10);
    src_en = 1'b0;
    repeat (2) tick();
    check("toggle_outs", 32'(out_idx), 32'(in_idx));
    check("toggle_data", 32'(data_errs), 0);
    check("toggle_mirror", 32'(mirror_errs), 0);
    mirror_en = 1'b0;
    toggle_mode = 1'b0;

    // Full frame with downstream consuming lines
    do_reset();
    auto_en = 1'b1;
    src_en = 1'b1;
    start_frame();
    budget = 0;
    while (done_cnt == 0 && budget < 1000) begin
      tick();
      budget++;
    end
    check("frame_done_seen", 32'(done_cnt), 1);
    repeat (10) tick();
    check("frame_real_pixels", 32'(in_idx), 48);
    check("frame_total_pixels", 32'(out_idx), 64);
    check("frame_data", 32'(data_errs), 0);
    check("frame_done_once", 32'(done_cnt), 1);
    check("frame_done_lines", 32'(done_lines), 6);
    check("frame_done_busy", 32'(done_busy), 0);
    check("frame_busy_after", 32'(o_busy), 0);
    check("frame_lines_out", 32'(o_lines_out), 6);

    // Reset asserted while padding, then a fresh frame
    do_reset();
    auto_en = 1'b1;
    src_en = 1'b1;
    start_frame();
    budget = 0;
    while (out_idx < 52 && budget < 1000) begin
      tick();
      budget++;
    end
    check("pad_reached_inputs", 32'(in_idx), 48);
    do_reset();
    check("midpad_rst_ready", 32'(o_s_ready), 0);
    check("midpad_rst_valid", 32'(o_pixel_data_valid), 0);
    check("midpad_rst_data", 32'(o_pixel_data), 0);
    check("midpad_rst_busy", 32'(o_busy), 0);
    check("midpad_rst_done", 32'(o_frame_done), 0);
    check("midpad_rst_lines_out", 32'(o_lines_out), 0);
    src_en = 1'b1;
    start_frame();
    repeat (60) tick();
    check("restart_xfers", 32'(in_idx), 32);
    check("restart_ready", 32'(o_s_ready), 0);
    check("restart_no_done", 32'(done_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
